// File: rtl/bist_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : bist_sequencer                                                    |
// | Purpose : Clock-enable sequencer for the TRNG -> hash -> MISR datapath with |
// |           free-running normal mode and a fixed-length BIST with signature   |
// |           check. Optional SEQ_GOLDEN_PORT_EN adds a run-time golden input.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module bist_sequencer #(
  parameter int unsigned       SIG_W    = 32,
  parameter int unsigned       WARM_CYC = 16,
  parameter int unsigned       MIX_CYC  = 8,
  parameter int unsigned       ROUNDS   = 64,
  parameter logic [SIG_W-1:0]  GOLDEN   = '0,
  localparam int unsigned      ROUND_W  = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               bist_i,
  input  logic [SIG_W-1:0]   signature_i,
`ifdef SEQ_GOLDEN_PORT_EN
  input  logic [SIG_W-1:0]   golden_i,
`endif
  output logic               trng_en_o,
  output logic               hash_en_o,
  output logic               hash_load_o,
  output logic               normal_mode_o,
  output logic               misr_en_o,
  output logic               datapath_clr_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [ROUND_W-1:0] round_o
);

  localparam int unsigned CNT_MAX = (WARM_CYC > MIX_CYC) ? WARM_CYC : MIX_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   WARM_LAST  = CNT_W'(WARM_CYC - 1);
  localparam logic [CNT_W-1:0]   MIX_LAST   = CNT_W'(MIX_CYC - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_NORMAL = 4'd1,
    S_CLEAR  = 4'd2,
    S_WARM   = 4'd3,
    S_LOAD   = 4'd4,
    S_MIX    = 4'd5,
    S_SHIFT  = 4'd6,
    S_CHECK  = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  logic trng_en_q, trng_en_d;
  logic hash_en_q, hash_en_d;
  logic hash_load_q, hash_load_d;
  logic normal_q, normal_d;
  logic misr_en_q, misr_en_d;
  logic clr_q, clr_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [SIG_W-1:0] golden_w;
  logic             match_w;
  logic             bist_active_w;

`ifdef SEQ_GOLDEN_PORT_EN
  logic [SIG_W-1:0] golden_q, golden_d;
  assign golden_w = golden_q;
`else
  assign golden_w = GOLDEN;
`endif

  assign match_w       = (signature_i == golden_w);
  assign bist_active_w = (state_q == S_CLEAR) || (state_q == S_WARM) ||
                         (state_q == S_LOAD)  || (state_q == S_MIX)  ||
                         (state_q == S_SHIFT) || (state_q == S_CHECK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
`ifdef SEQ_GOLDEN_PORT_EN
    golden_d = golden_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          round_d = '0;
          cnt_d   = '0;
          state_d = bist_i ? S_CLEAR : S_NORMAL;
`ifdef SEQ_GOLDEN_PORT_EN
          // Captured on the start edge so the value is stable for the whole run.
          if (bist_i) golden_d = golden_i;
`endif
        end
      end
      S_NORMAL: begin
        if (!run_i) state_d = S_IDLE;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_WARM;
      end
      S_WARM: begin
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_MIX;
      end
      S_MIX: begin
        if (cnt_q == MIX_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        round_d = round_q + ROUND_W'(1);
        state_d = (round_q == ROUND_LAST) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        pass_d  = match_w;
        fail_d  = ~match_w;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!run_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping run aborts any in-flight BIST without reporting a result.
    if (!run_i && bist_active_w) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      round_d = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    trng_en_d   = 1'b0;
    hash_en_d   = 1'b0;
    hash_load_d = 1'b0;
    normal_d    = 1'b0;
    misr_en_d   = 1'b0;
    clr_d       = 1'b0;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE:   ready_d = 1'b1;
      S_NORMAL: begin
        trng_en_d = 1'b1;
        hash_en_d = 1'b1;
        normal_d  = 1'b1;
        busy_d    = 1'b1;
      end
      S_CLEAR: begin
        clr_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_WARM: begin
        trng_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_LOAD: begin
        trng_en_d   = 1'b1;
        hash_en_d   = 1'b1;
        hash_load_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_MIX: begin
        trng_en_d = 1'b1;
        hash_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_SHIFT: begin
        trng_en_d = 1'b1;
        misr_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_CHECK:  busy_d = 1'b1;
      S_DONE: begin
        done_d  = 1'b1;
        ready_d = 1'b1;
      end
      default:  ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      round_q     <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      trng_en_q   <= 1'b0;
      hash_en_q   <= 1'b0;
      hash_load_q <= 1'b0;
      normal_q    <= 1'b0;
      misr_en_q   <= 1'b0;
      clr_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_GOLDEN_PORT_EN
      golden_q    <= GOLDEN;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      round_q     <= round_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      trng_en_q   <= trng_en_d;
      hash_en_q   <= hash_en_d;
      hash_load_q <= hash_load_d;
      normal_q    <= normal_d;
      misr_en_q   <= misr_en_d;
      clr_q       <= clr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_GOLDEN_PORT_EN
      golden_q    <= golden_d;
`endif
    end
  end

  assign trng_en_o      = trng_en_q;
  assign hash_en_o      = hash_en_q;
  assign hash_load_o    = hash_load_q;
  assign normal_mode_o  = normal_q;
  assign misr_en_o      = misr_en_q;
  assign datapath_clr_o = clr_q;
  assign ready_o        = ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign round_o        = round_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_bist_sequencer                                                 |
// | Purpose : Scoreboard bench for bist_sequencer; event times come from the    |
// |           closed-form BIST schedule. Honours SEQ_GOLDEN_PORT_EN.            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bist_sequencer;

  localparam int          WARM     = 4;
  localparam int          MIX      = 3;
  localparam int          RNDS     = 2;
  localparam logic [31:0] GOLD     = 32'hDEADBEEF;
  localparam int          RW       = $clog2(RNDS + 1);
  localparam int          DONE_LAT = 2 + WARM + RNDS * (MIX + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          bist = 1'b0;
  logic [31:0]   signature = '0;
`ifdef SEQ_GOLDEN_PORT_EN
  logic [31:0]   golden = GOLD;
`endif
  logic          trng_en, hash_en, hash_load, normal_mode, misr_en, clr;
  logic          ready, busy, done, pass, fail;
  logic [RW-1:0] round;

  bist_sequencer #(
    .SIG_W(32), .WARM_CYC(WARM), .MIX_CYC(MIX), .ROUNDS(RNDS), .GOLDEN(GOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .bist_i(bist), .signature_i(signature),
`ifdef SEQ_GOLDEN_PORT_EN
    .golden_i(golden),
`endif
    .trng_en_o(trng_en), .hash_en_o(hash_en), .hash_load_o(hash_load),
    .normal_mode_o(normal_mode), .misr_en_o(misr_en), .datapath_clr_o(clr),
    .ready_o(ready), .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail),
    .round_o(round)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            at;
    logic          p;
    logic          f;
    logic [RW-1:0] r;
  } done_t;

  int    exp_load_q[$];
  int    exp_misr_q[$];
  done_t exp_done_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schedule for a BIST run whose CLEAR is entered at edge e; events at or after cutoff never happen.
  task automatic push_schedule(input int e, input int cutoff, input bit with_done, input logic p);
    done_t d;
    for (int r = 0; r < RNDS; r++) begin
      if (e + 1 + WARM + r * (MIX + 2) < cutoff) exp_load_q.push_back(e + 1 + WARM + r * (MIX + 2));
      if (e + WARM + MIX + 2 + r * (MIX + 2) < cutoff) exp_misr_q.push_back(e + WARM + MIX + 2 + r * (MIX + 2));
    end
    if (with_done) begin
      d.at = e + DONE_LAT;
      d.p  = p;
      d.f  = ~p;
      d.r  = RW'(RNDS);
      exp_done_q.push_back(d);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    int    ex;
    done_t d;
    if (hash_load) begin
      ex = (exp_load_q.size() > 0) ? exp_load_q.pop_front() : -1;
      check("hash_load_cycle", cyc, ex);
      check("hash_load_qual", {trng_en, hash_en}, 2'b11);
    end
    if (misr_en) begin
      ex = (exp_misr_q.size() > 0) ? exp_misr_q.pop_front() : -1;
      check("misr_en_cycle", cyc, ex);
    end
    if (done && !done_prev) begin
      if (exp_done_q.size() > 0) begin
        d = exp_done_q.pop_front();
        check("done_cycle", cyc, d.at);
        check("done_pass", pass, d.p);
        check("done_fail", fail, d.f);
        check("done_round", round, d.r);
      end else begin
        check("done_cycle", cyc, -1);
      end
    end
    done_prev <= done;
  end

  task automatic check_idle(input string tag, input logic p, input logic f);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, p);
    check({tag, "_fail"}, fail, f);
    check({tag, "_en"}, {trng_en, hash_en, hash_load, normal_mode, misr_en, clr}, 0);
  endtask

  task automatic run_bist(input logic [31:0] mis_sig, input bit match, input int abort_off);
    int          e;
    logic [31:0] g;
    logic [31:0] s;
    logic        p;
    @(negedge clk);
`ifdef SEQ_GOLDEN_PORT_EN
    g = ($urandom_range(0, 1) == 1) ? GOLD : $urandom;
    golden = g;
`else
    g = GOLD;
`endif
    s = match ? g : mis_sig;
    p = (s == g);
    signature = s;
    run = 1'b1;
    bist = 1'b1;
    e = cyc + 1;
    push_schedule(e, (abort_off > 0) ? e + abort_off : e + DONE_LAT + 1, abort_off == 0, p);
    @(negedge clk);
    check("clear_strobe", clr, 1);
    check("clear_busy", busy, 1);
    check("clear_result", {pass, fail, round}, 0);
    if (abort_off > 0) begin
      for (int i = 1; i < abort_off; i++) begin
        bist = 1'($urandom_range(0, 1));
`ifdef SEQ_GOLDEN_PORT_EN
        golden = $urandom;
`endif
        @(negedge clk);
      end
      run = 1'b0;
      @(negedge clk);
      check_idle("abort", 0, 0);
    end else begin
      for (int i = 1; i <= DONE_LAT; i++) begin
        bist = 1'($urandom_range(0, 1));
`ifdef SEQ_GOLDEN_PORT_EN
        golden = $urandom;
`endif
        @(negedge clk);
      end
      check("done_level", {done, ready, busy}, 3'b110);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("done_hold", {done, pass, fail}, {1'b1, p, ~p});
      end
      run = 1'b0;
      @(negedge clk);
      check_idle("after_done", p, ~p);
    end
  endtask

  task automatic run_normal(input int len);
    @(negedge clk);
    run = 1'b1;
    bist = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check("normal_en", {trng_en, hash_en, normal_mode, busy, ready}, 5'b11110);
      check("normal_result", {pass, fail, done}, 0);
      bist = 1'($urandom_range(0, 1));
    end
    run = 1'b0;
    @(negedge clk);
    check_idle("normal_stop", 0, 0);
  endtask

  task automatic reset_in_shift();
    int e;
    @(negedge clk);
    signature = GOLD;
`ifdef SEQ_GOLDEN_PORT_EN
    golden = GOLD;
`endif
    run = 1'b1;
    bist = 1'b1;
    e = cyc + 1;
    push_schedule(e, e + WARM + MIX + 3, 0, 1'b0);
    repeat (WARM + MIX + 3) @(negedge clk);
    check("shift_before_reset", misr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset", 0, 0);
    check("async_reset_round", round, 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("in_reset", 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_release", 0, 0);
    check("reset_round", round, 0);

    run_bist(32'h0, 1'b1, 0);
    run_bist(32'h0, 1'b0, 0);
    run_bist(32'h0, 1'b1, 0);
    run_normal(6);
    run_bist(32'h0, 1'b1, 7);
    run_bist(32'h0, 1'b1, 0);
    reset_in_shift();
    run_bist(32'h0, 1'b0, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: run_normal($urandom_range(1, 10));
        1: run_bist($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, DONE_LAT));
        2: run_bist($urandom, 1'($urandom_range(0, 1)), 0);
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
    end

    repeat (3) @(negedge clk);
    check("load_queue_drained", exp_load_q.size(), 0);
    check("misr_queue_drained", exp_misr_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
